// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DefaultDw = 8;
    localparam int unsigned Depth     = 16;
    localparam int unsigned DefaultAw = $clog2(Depth);
    localparam int unsigned ObufDepth = 2;
    localparam int unsigned LevelW    = 5;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshakes, external RAM ports and status flags of ram_fifo_ctrl.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          write;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic          read;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    // Controller side
    modport master (
        input  in_valid, in_data, out_ready, data_out,
        output in_ready, out_valid, out_data, write, wr_addr, data_in,
               read, rd_addr, full, empty
    );

    // Environment side: producer, consumer and RAM
    modport slave (
        output in_valid, in_data, out_ready, data_out,
        input  in_ready, out_valid, out_data, write, wr_addr, data_in,
               read, rd_addr, full, empty
    );

endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer; head holds the oldest word and drives out_data.
module ram_fifo_obuf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);
    logic [DW-1:0] mem_q [ObufDepth];
    logic [DW-1:0] mem_d [ObufDepth];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;

    // Next-state: push writes the tail, pop advances the head
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ObufDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM with a one-cycle read latency.
// Optional: define RAM_FIFO_LEVEL_EN to add the registered occupancy output 'level'.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned AW = DefaultAw
) (
    input logic clk,
    input logic rst_n,
    ram_fifo_ctrl_if.master bus
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [LevelW-1:0] level
`endif
);
    localparam logic [AW:0] CntFull = (AW + 1)'(1 << AW);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q, inflight_d;
    logic          in_ready, wr_en, rd_en, pop, push;
    logic [1:0]    buf_cnt;
    logic [DW-1:0] buf_head;
    logic [2:0]    occ;

    ram_fifo_obuf #(
        .DW(DW)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (bus.data_out),
        .pop_i       (pop),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

    // Handshakes, RAM read scheduling and pointer/count next-state
    always_comb begin
        in_ready = (ram_cnt_q < CntFull) && rst_n;
        wr_en    = bus.in_valid && in_ready;
        pop      = (buf_cnt != 2'd0) && bus.out_ready;
        // Read data returns the cycle after the read and always lands in the buffer
        push     = inflight_q;
        // Slots already claimed once this cycle's pop is taken into account
        occ      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en    = rst_n && (ram_cnt_q != '0) && (occ < 3'd2);
        wp_d     = wr_en ? wp_q + AW'(1) : wp_q;
        rp_d     = rd_en ? rp_q + AW'(1) : rp_q;
        ram_cnt_d = ram_cnt_q;
        unique case ({wr_en, rd_en})
            2'b10:   ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
        inflight_d = rd_en;
    end

    // Pointer, count and in-flight registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (buf_cnt != 2'd0);
    assign bus.out_data  = buf_head;
    assign bus.write     = wr_en;
    assign bus.wr_addr   = wp_q;
    assign bus.data_in   = bus.in_data;
    assign bus.read      = rd_en;
    assign bus.rd_addr   = rp_q;
    assign bus.full      = (ram_cnt_q == CntFull);
    assign bus.empty     = (ram_cnt_q == '0) && !inflight_q && (buf_cnt == 2'd0);

`ifdef RAM_FIFO_LEVEL_EN
    logic [LevelW-1:0] level_q, level_d;
    logic [1:0]        buf_cnt_nxt;

    // Total occupancy after this cycle's updates
    always_comb begin
        buf_cnt_nxt = buf_cnt + {1'b0, push} - {1'b0, pop};
        level_d     = LevelW'(ram_cnt_d) + LevelW'(inflight_d) + LevelW'(buf_cnt_nxt);
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule
